// File: rtl/ptv_pkg.sv
// Shared types and coin decoding for the parking-ticket kiosk scheduler.
package ptv_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StIssue,
    StRefund
  } state_e;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;
  localparam logic [1:0] COIN_BAD  = 2'b11;

  // Illegal and empty codes both carry no credit.
  function automatic logic [3:0] coin_value(input logic [1:0] code);
    case (code)
      COIN_5:  return 4'd5;
      COIN_10: return 4'd10;
      default: return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/ptv_kiosk_scheduler_if.sv
// Kiosk-side and printer/dispenser-side signals of the ticket scheduler.
interface ptv_kiosk_scheduler_if #(
  parameter int unsigned N_KIOSK = 4,
  parameter int unsigned CW      = 6
);
  localparam int unsigned IW = (N_KIOSK > 1) ? $clog2(N_KIOSK) : 1;

  logic [N_KIOSK-1:0]   req;
  logic [N_KIOSK-1:0]   coin_valid;
  logic [2*N_KIOSK-1:0] coin_in;
  logic [N_KIOSK-1:0]   gnt;
  logic                 busy;
  logic                 ticket;
  logic [IW-1:0]        ticket_id;
  logic                 refund;
  logic                 ret_valid;
  logic [CW-1:0]        ret_amt;
  logic                 coin_rej;

  modport master (
    output req, coin_valid, coin_in,
    input  gnt, busy, ticket, ticket_id, refund, ret_valid, ret_amt, coin_rej
  );

  modport slave (
    input  req, coin_valid, coin_in,
    output gnt, busy, ticket, ticket_id, refund, ret_valid, ret_amt, coin_rej
  );

endinterface

// File: rtl/ptv_rr_arbiter.sv
// Combinational round-robin picker: first requester at or above rr_ptr_i, wrapping.
module ptv_rr_arbiter #(
  parameter int unsigned N_KIOSK = 4,
  localparam int unsigned IW = (N_KIOSK > 1) ? $clog2(N_KIOSK) : 1
) (
  input  logic [N_KIOSK-1:0] req_i,
  input  logic [IW-1:0]      rr_ptr_i,
  output logic [N_KIOSK-1:0] winner_o,
  output logic [IW-1:0]      idx_o,
  output logic               any_o
);

  logic [IW:0] k;

  always_comb begin
    k        = '0;
    winner_o = '0;
    idx_o    = '0;
    any_o    = |req_i;
    // Scan from the farthest offset down so the closest requester wins last.
    for (int off = N_KIOSK - 1; off >= 0; off--) begin
      k = {1'b0, rr_ptr_i} + (IW+1)'(off);
      if (k >= (IW+1)'(N_KIOSK)) k = k - (IW+1)'(N_KIOSK);
      if (req_i[k[IW-1:0]]) begin
        idx_o    = k[IW-1:0];
        winner_o = N_KIOSK'(1) << k[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/ptv_kiosk_scheduler.sv
// Shares one ticket engine between kiosks: grant, collect coins, issue or refund.
module ptv_kiosk_scheduler
  import ptv_pkg::*;
#(
  parameter int unsigned N_KIOSK = 4,
  parameter int unsigned PRICE   = 15,
  parameter int unsigned CW      = 6,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  ptv_kiosk_scheduler_if.slave bus
);

  localparam int unsigned IW = (N_KIOSK > 1) ? $clog2(N_KIOSK) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT);

  state_e              state_q, state_d;
  logic [IW-1:0]       gidx_q, gidx_d, rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]       credit_q, credit_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [N_KIOSK-1:0]  gnt_q, gnt_d;
  logic                busy_q, busy_d, ticket_q, ticket_d, refund_q, refund_d;
  logic                ret_valid_q, ret_valid_d, coin_rej_q, coin_rej_d;
  logic [IW-1:0]       ticket_id_q, ticket_id_d;
  logic [CW-1:0]       ret_amt_q, ret_amt_d;

  logic [N_KIOSK-1:0]  arb_winner;
  logic [IW-1:0]       arb_idx;
  logic                arb_any;
  logic [1:0]          code;
  logic                coin_v, req_g;
  logic [CW-1:0]       coin_amt, credit_sum;

  ptv_rr_arbiter #(.N_KIOSK(N_KIOSK)) u_arb (
    .req_i    (bus.req),
    .rr_ptr_i (rr_ptr_q),
    .winner_o (arb_winner),
    .idx_o    (arb_idx),
    .any_o    (arb_any)
  );

  always_comb begin
    state_d     = state_q;
    gidx_d      = gidx_q;
    rr_ptr_d    = rr_ptr_q;
    credit_d    = credit_q;
    timer_d     = timer_q;
    gnt_d       = gnt_q;
    ticket_d    = 1'b0;
    ticket_id_d = '0;
    refund_d    = 1'b0;
    ret_valid_d = 1'b0;
    ret_amt_d   = '0;
    coin_rej_d  = 1'b0;
    code        = bus.coin_in[{gidx_q, 1'b0} +: 2];
    coin_v      = bus.coin_valid[gidx_q];
    req_g       = bus.req[gidx_q];
    coin_amt    = CW'(coin_value(code));
    credit_sum  = credit_q + coin_amt;

    unique case (state_q)
      StIdle: begin
        if (arb_any) begin
          state_d  = StCollect;
          gidx_d   = arb_idx;
          gnt_d    = arb_winner;
          credit_d = '0;
          timer_d  = '0;
        end
      end
      StCollect: begin
        coin_rej_d = req_g && coin_v && (code == COIN_BAD);
        // A dropped request beats any coin; a legal coin beats timer expiry.
        if (req_g && coin_v && (coin_amt != '0)) begin
          credit_d = credit_sum;
          timer_d  = '0;
          if (credit_sum >= CW'(PRICE)) begin
            state_d     = StIssue;
            gnt_d       = '0;
            ticket_d    = 1'b1;
            ticket_id_d = gidx_q;
            ret_amt_d   = credit_sum - CW'(PRICE);
            ret_valid_d = (credit_sum != CW'(PRICE));
          end
        end else if (!req_g || (timer_q == TW'(TIMEOUT - 2))) begin
          state_d     = StRefund;
          gnt_d       = '0;
          refund_d    = 1'b1;
          ret_amt_d   = credit_q;
          ret_valid_d = (credit_q != '0);
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StIssue, StRefund: begin
        state_d  = StIdle;
        credit_d = '0;
        timer_d  = '0;
        rr_ptr_d = (gidx_q == IW'(N_KIOSK - 1)) ? '0 : gidx_q + 1'b1;
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      gidx_q      <= '0;
      rr_ptr_q    <= '0;
      credit_q    <= '0;
      timer_q     <= '0;
      gnt_q       <= '0;
      busy_q      <= 1'b0;
      ticket_q    <= 1'b0;
      ticket_id_q <= '0;
      refund_q    <= 1'b0;
      ret_valid_q <= 1'b0;
      ret_amt_q   <= '0;
      coin_rej_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      gidx_q      <= gidx_d;
      rr_ptr_q    <= rr_ptr_d;
      credit_q    <= credit_d;
      timer_q     <= timer_d;
      gnt_q       <= gnt_d;
      busy_q      <= busy_d;
      ticket_q    <= ticket_d;
      ticket_id_q <= ticket_id_d;
      refund_q    <= refund_d;
      ret_valid_q <= ret_valid_d;
      ret_amt_q   <= ret_amt_d;
      coin_rej_q  <= coin_rej_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.busy      = busy_q;
  assign bus.ticket    = ticket_q;
  assign bus.ticket_id = ticket_id_q;
  assign bus.refund    = refund_q;
  assign bus.ret_valid = ret_valid_q;
  assign bus.ret_amt   = ret_amt_q;
  assign bus.coin_rej  = coin_rej_q;

endmodule

// File: tb/tb_ptv_kiosk_scheduler.sv
// Directed bench for ptv_kiosk_scheduler and its round-robin picker.
module tb_ptv_kiosk_scheduler;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  ptv_kiosk_scheduler_if #(.N_KIOSK(4), .CW(6)) kif ();

  ptv_kiosk_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (kif)
  );

  logic [3:0] arb_req;
  logic [1:0] arb_ptr;
  logic [3:0] arb_winner;
  logic [1:0] arb_idx;
  logic       arb_any;

  ptv_rr_arbiter #(.N_KIOSK(4)) u_arb (
    .req_i    (arb_req),
    .rr_ptr_i (arb_ptr),
    .winner_o (arb_winner),
    .idx_o    (arb_idx),
    .any_o    (arb_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // {gnt, busy, ticket, ticket_id, refund, ret_valid, ret_amt, coin_rej}
  function automatic logic [16:0] outs();
    return {kif.gnt, kif.busy, kif.ticket, kif.ticket_id, kif.refund, kif.ret_valid,
            kif.ret_amt, kif.coin_rej};
  endfunction

  function automatic logic [16:0] mk(input logic [3:0] g, input logic b, input logic t,
                                     input logic [1:0] id, input logic rf, input logic rv,
                                     input logic [5:0] amt, input logic rj);
    return {g, b, t, id, rf, rv, amt, rj};
  endfunction

  task automatic chk_out(input string tag, input logic [16:0] exp);
    chk(tag, 32'(outs()), 32'(exp));
  endtask

  task automatic coin(input int k, input logic [1:0] code);
    kif.coin_valid          = 4'b0001 << k;
    kif.coin_in             = '0;
    kif.coin_in[2*k +: 2]   = code;
    tick();
    kif.coin_valid          = '0;
    kif.coin_in             = '0;
  endtask

  task automatic chk_arb(input string tag, input logic [3:0] rq, input logic [1:0] ptr,
                         input logic [3:0] w, input logic [1:0] idx, input logic any);
    arb_req = rq;
    arb_ptr = ptr;
    #1;
    chk(tag, 32'({arb_winner, arb_idx, arb_any}), 32'({w, idx, any}));
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    rst            = 1'b0;
    kif.req        = '0;
    kif.coin_valid = '0;
    kif.coin_in    = '0;
    arb_req        = '0;
    arb_ptr        = '0;

    // Standalone picker, including wrap past the top index.
    chk_arb("arb_ptr1", 4'b1001, 2'd1, 4'b1000, 2'd3, 1'b1);
    chk_arb("arb_wrap", 4'b0011, 2'd3, 4'b0001, 2'd0, 1'b1);
    chk_arb("arb_wrap2", 4'b0110, 2'd3, 4'b0010, 2'd1, 1'b1);
    chk_arb("arb_ptr2", 4'b1111, 2'd2, 4'b0100, 2'd2, 1'b1);
    chk_arb("arb_none", 4'b0000, 2'd2, 4'b0000, 2'd0, 1'b0);

    repeat (3) tick();
    chk_out("reset", mk(4'b0000, 0, 0, 0, 0, 0, 0, 0));
    rst = 1'b1;

    // Kiosk0: 5 + 10 gives exact fare, no change.
    kif.req = 4'b0001;
    tick();
    chk_out("a_grant", mk(4'b0001, 1, 0, 0, 0, 0, 0, 0));
    coin(0, 2'b01);
    chk_out("a_coin5", mk(4'b0001, 1, 0, 0, 0, 0, 0, 0));
    coin(0, 2'b10);
    chk_out("a_ticket", mk(4'b0000, 1, 1, 0, 0, 0, 0, 0));
    kif.req = '0;
    tick();
    chk_out("a_idle", mk(4'b0000, 0, 0, 0, 0, 0, 0, 0));

    // Kiosk2: 10 + 10 gives change 5.
    kif.req = 4'b0100;
    tick();
    chk_out("b_grant", mk(4'b0100, 1, 0, 0, 0, 0, 0, 0));
    coin(2, 2'b10);
    chk_out("b_coin10", mk(4'b0100, 1, 0, 0, 0, 0, 0, 0));
    coin(2, 2'b10);
    chk_out("b_ticket", mk(4'b0000, 1, 1, 2, 0, 1, 5, 0));
    kif.req = '0;
    tick();
    chk_out("b_idle", mk(4'b0000, 0, 0, 0, 0, 0, 0, 0));

    // Fresh pointer, all kiosks requesting: grants rotate 0,1,2,3,0.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    kif.req = 4'b1111;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk_out($sformatf("c_grant%0d", i), mk(4'b0001 << (i % 4), 1, 0, 0, 0, 0, 0, 0));
      chk($sformatf("c_onehot%0d", i), 32'($onehot(kif.gnt)), 32'd1);
      coin(i % 4, 2'b01);
      coin(i % 4, 2'b10);
      chk_out($sformatf("c_ticket%0d", i), mk(4'b0000, 1, 1, 2'(i % 4), 0, 0, 0, 0));
      if (i == 4) kif.req = '0;
      tick();
      chk_out($sformatf("c_gap%0d", i), mk(4'b0000, 0, 0, 0, 0, 0, 0, 0));
      if (i < 4) tick();
    end

    // Kiosk1 idles after a 10 coin: refund of 10 after 63 idle cycles.
    kif.req = 4'b0010;
    tick();
    chk_out("d_grant", mk(4'b0010, 1, 0, 0, 0, 0, 0, 0));
    coin(1, 2'b10);
    repeat (62) tick();
    chk_out("d_pre_timeout", mk(4'b0010, 1, 0, 0, 0, 0, 0, 0));
    tick();
    chk_out("d_refund", mk(4'b0000, 1, 0, 0, 1, 1, 10, 0));
    kif.req = '0;
    tick();
    chk_out("d_idle", mk(4'b0000, 0, 0, 0, 0, 0, 0, 0));

    // Same, but a 5 coin lands on the expiry cycle and completes the fare.
    kif.req = 4'b0010;
    tick();
    chk_out("d2_grant", mk(4'b0010, 1, 0, 0, 0, 0, 0, 0));
    coin(1, 2'b10);
    repeat (62) tick();
    coin(1, 2'b01);
    chk_out("d2_ticket", mk(4'b0000, 1, 1, 1, 0, 0, 0, 0));
    kif.req = '0;
    tick();

    // Kiosk0: foreign coin ignored, illegal coin rejected, drop beats a coin.
    kif.req = 4'b0001;
    tick();
    chk_out("e_grant", mk(4'b0001, 1, 0, 0, 0, 0, 0, 0));
    coin(3, 2'b10);
    chk_out("e_foreign", mk(4'b0001, 1, 0, 0, 0, 0, 0, 0));
    coin(0, 2'b11);
    chk_out("e_rej", mk(4'b0001, 1, 0, 0, 0, 0, 0, 1));
    tick();
    chk_out("e_rej_clear", mk(4'b0001, 1, 0, 0, 0, 0, 0, 0));
    coin(0, 2'b01);
    chk_out("e_coin5", mk(4'b0001, 1, 0, 0, 0, 0, 0, 0));
    kif.req = '0;
    coin(0, 2'b10);
    chk_out("e_drop_refund", mk(4'b0000, 1, 0, 0, 1, 1, 5, 0));
    tick();
    chk_out("e_idle", mk(4'b0000, 0, 0, 0, 0, 0, 0, 0));

    // Asynchronous reset mid-session discards credit silently.
    kif.req = 4'b0010;
    tick();
    chk_out("f_grant", mk(4'b0010, 1, 0, 0, 0, 0, 0, 0));
    coin(1, 2'b10);
    #2;
    rst = 1'b0;
    #1;
    chk_out("f_async", mk(4'b0000, 0, 0, 0, 0, 0, 0, 0));
    kif.req = 4'b0100;
    tick();
    chk_out("f_held", mk(4'b0000, 0, 0, 0, 0, 0, 0, 0));
    rst = 1'b1;
    tick();
    chk_out("f_grant2", mk(4'b0100, 1, 0, 0, 0, 0, 0, 0));
    coin(2, 2'b10);
    chk_out("f_credit0", mk(4'b0100, 1, 0, 0, 0, 0, 0, 0));
    coin(2, 2'b01);
    chk_out("f_ticket", mk(4'b0000, 1, 1, 2, 0, 0, 0, 0));
    kif.req = '0;
    tick();
    chk_out("f_idle", mk(4'b0000, 0, 0, 0, 0, 0, 0, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
